npc_seq_ctrl: RTL and testbench
===============================

// Module: npc_seq_ctrl
// PURPOSE
//  Multi-cycle instruction sequencer for the NPC core: sequences one instruction at a time through
//  fetch -> execute -> memory -> write-back and gates every architectural write.
//  Issues IFU/LSU requests, waits for their valid returns, then opens a one-cycle commit window in which
//  the write-back stage's PC, GPR and CSR writes take effect. Sits beside the datapath in the top level;
//  halts the core on ebreak.
// PARAMETERS
//  CNT_W      32    width of retired-instruction counter
//  WDT_LIMIT  1024  cycles allowed in S_FETCH/S_MEM before hang (watchdog only)
//  WDT_W      16    watchdog counter width; WDT_LIMIT < 2**WDT_W
// PORTS
//  clk           in   1      core clock
//  rst_n         in   1      asynchronous active-low reset
//  ifu_req       out  1      fetch request, held until ifu_valid
//  ifu_valid     in   1      instruction returned and decoded fields stable
//  opcode        in   7      decoded opcode of the current instruction
//  is_ebreak     in   1      current instruction is ebreak
//  lsu_req       out  1      memory request, held until lsu_valid
//  lsu_valid     in   1      load data / store ack returned
//  wbu_valid     in   1      write-back stage outputs valid
//  commit        out  1      one-cycle retire strobe
//  pc_wen        out  1      PC register load enable (dnpc)
//  gpr_wen_gate  out  1      AND-mask for the write-back GPR wen
//  csr_wen_gate  out  1      AND-mask for the write-back CSR wen
//  halt          out  1      sticky, core stopped by ebreak
//  hang          out  1      sticky, watchdog expired (0 when NPC_SEQ_WDT_EN undefined)
//  state_o       out  3      current FSM state, for debug/trace
//  inst_cnt      out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_IDLE; every output 0; inst_cnt=0. Takes effect immediately, even mid-operation.
//    No request is held over; a response arriving after reset is ignored.
//  - S_IDLE: after the first clk edge with rst_n=1, go to S_FETCH.
//  - S_FETCH: ifu_req=1.
//    - ifu_valid=0: stay.
//    - ifu_valid=1: sample opcode/is_ebreak into registers, go to S_EXEC.
//  - S_EXEC: one cycle (combinational EXU).
//    - Registered opcode is load (0000011) or store (0100011): go to S_MEM.
//    - Otherwise: go to S_WB.
//  - S_MEM: lsu_req=1 until lsu_valid, then go to S_WB.
//    - lsu_valid in the same cycle as entry is accepted (0-wait memory).
//  - S_WB: wait for wbu_valid.
//    - In the cycle wbu_valid=1, assert commit, pc_wen, gpr_wen_gate and csr_wen_gate together,
//      for exactly one cycle.
//    - inst_cnt increments on that edge and wraps modulo 2**CNT_W without a flag.
//    - Next state is S_FETCH, or S_HALT if the registered is_ebreak=1.
//  - S_HALT: terminal. halt=1; no req, gate or commit is asserted. Only reset exits.
//  - The ebreak instruction itself commits (its commit pulse precedes halt).
//  - Latency, non-memory instruction: ifu_valid edge -> commit is 2 cycles minimum (EXEC, WB).
//  - Latency, load/store with 0-wait memory: 3 cycles minimum.
//  - Req/valid rule: a req stays high until its valid is sampled. A valid without an outstanding req is ignored.
//  - Gates are 0 outside the commit cycle, so no GPR or CSR write can occur during fetch or memory wait.
//  - State encoding: S_IDLE=0, S_FETCH=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=5.
//    Codes 6 and 7 go to S_IDLE on the next edge.
// CONFIGURATION
//  NPC_SEQ_WDT_EN defined:
//  - Watchdog counter clears on every state change and counts cycles spent in S_FETCH or S_MEM.
//  - When the count reaches WDT_LIMIT, hang=1 (sticky), halt=1, and the FSM moves to S_HALT.
//  - The pending req drops in the same cycle.
//  - A valid arriving in the expiry cycle is ignored.
//  NPC_SEQ_WDT_EN undefined: no counter is instantiated, hang is tied to 0, and waits are unbounded.
// STRUCTURE
//  - Package npc_pkg: state encoding constants, OP_LOAD/OP_STORE/OP_JAL/OP_JALR/OP_SYSTEM opcode constants.
//  - Sub-module seq_watchdog (clk, rst_n, clr, en -> expired), instantiated only under NPC_SEQ_WDT_EN.
//  - FSM, request/gate logic and inst_cnt live in this module.
// TESTING
//  1. Reset, then an addi: ifu_valid 1 cycle after ifu_req -> state 1,2,4,1.
//     commit/pc_wen/gates high exactly 1 cycle when wbu_valid=1; inst_cnt=1.
//  2. lw, lsu_valid delayed 5 cycles: lsu_req high 5 cycles, gates stay 0 throughout.
//     Commit occurs 1 cycle after lsu_valid; inst_cnt increments.
//  3. ebreak after 3 instructions: 4th commit pulses, then halt=1, inst_cnt=4.
//     Later ifu_valid/lsu_valid pulses produce no req and no commit.
//  4. Drive rst_n=0 mid-S_MEM with lsu_req=1: lsu_req, commit and gates go 0 immediately; state_o=0.
//     A stale lsu_valid after release is ignored and the next fetch proceeds normally.
//  5. NPC_SEQ_WDT_EN, WDT_LIMIT=8, ifu_valid never asserted: hang=1 and halt=1 after 8 S_FETCH cycles; ifu_req drops.
//     Without the macro: still in S_FETCH after 100 cycles, hang=0.
//  6. inst_cnt preloaded via force to 2**CNT_W-1, then one commit: inst_cnt=0, no other side effect.

Source files
------------

// File: rtl/npc_seq_ctrl_pkg.sv
// Shared state encoding and opcode constants for the NPC instruction sequencer.
package npc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/npc_seq_ctrl_watchdog.sv
// Wait-state watchdog: counts enabled cycles and flags expiry once LIMIT cycles have elapsed.
module seq_watchdog #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  assign expired = en && (cnt == W'(LIMIT));

  // Saturates at LIMIT so a long stall cannot wrap back below the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/npc_seq_ctrl.sv
// NPC multi-cycle sequencer: fetch -> exec -> mem -> write-back with a one-cycle commit window.
// Optional wait-state watchdog enabled by defining NPC_SEQ_WDT_EN.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter int unsigned CNT_W     = 32
`ifdef NPC_SEQ_WDT_EN
  ,
  parameter int unsigned WDT_LIMIT = 1024,
  parameter int unsigned WDT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req,
  input  logic             ifu_valid,
  input  logic [6:0]       opcode,
  input  logic             is_ebreak,
  output logic             lsu_req,
  input  logic             lsu_valid,
  input  logic             wbu_valid,
  output logic             commit,
  output logic             pc_wen,
  output logic             gpr_wen_gate,
  output logic             csr_wen_gate,
  output logic             halt,
  output logic             hang,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] inst_cnt
);

  state_t     state;
  logic [6:0] op_q;
  logic       ebreak_q;
  logic       waiting;
  logic       wdt_exp;

  assign waiting = (state == S_FETCH) || (state == S_MEM);

`ifdef NPC_SEQ_WDT_EN
  seq_watchdog #(
    .LIMIT (WDT_LIMIT),
    .W     (WDT_W)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting),
    .en      (waiting),
    .expired (wdt_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hang <= 1'b0;
    else if (wdt_exp) hang <= 1'b1;
  end
`else
  assign wdt_exp = 1'b0;
  assign hang    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      ebreak_q <= 1'b0;
      inst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          // Expiry wins over a valid arriving in the same cycle.
          if (wdt_exp) begin
            state <= S_HALT;
          end else if (ifu_valid) begin
            op_q     <= opcode;
            ebreak_q <= is_ebreak;
            state    <= S_EXEC;
          end
        end
        S_EXEC:  state <= is_mem_op(op_q) ? S_MEM : S_WB;
        S_MEM: begin
          if (wdt_exp)        state <= S_HALT;
          else if (lsu_valid) state <= S_WB;
        end
        S_WB: begin
          if (wbu_valid) begin
            inst_cnt <= inst_cnt + 1'b1;
            state    <= ebreak_q ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the commit window additionally needs wbu_valid.
  assign ifu_req      = (state == S_FETCH) && !wdt_exp;
  assign lsu_req      = (state == S_MEM) && !wdt_exp;
  assign commit       = (state == S_WB) && wbu_valid;
  assign pc_wen       = commit;
  assign gpr_wen_gate = commit;
  assign csr_wen_gate = commit;
  assign halt         = (state == S_HALT);
  assign state_o      = state;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Self-checking bench for npc_seq_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_npc_seq_ctrl;

  localparam int CW = 8;
`ifdef NPC_SEQ_WDT_EN
  localparam int WDT = 8;
`endif
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_valid = 1'b0, lsu_valid = 1'b0, wbu_valid = 1'b0, is_ebreak = 1'b0;
  logic [6:0]    opcode = '0;
  logic          ifu_req, lsu_req, commit, pc_wen, gpr_wen_gate, csr_wen_gate, halt, hang;
  logic [2:0]    state_o;
  logic [CW-1:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  npc_seq_ctrl #(
    .CNT_W (CW)
`ifdef NPC_SEQ_WDT_EN
    , .WDT_LIMIT (WDT), .WDT_W (16)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req      (ifu_req),
    .ifu_valid    (ifu_valid),
    .opcode       (opcode),
    .is_ebreak    (is_ebreak),
    .lsu_req      (lsu_req),
    .lsu_valid    (lsu_valid),
    .wbu_valid    (wbu_valid),
    .commit       (commit),
    .pc_wen       (pc_wen),
    .gpr_wen_gate (gpr_wen_gate),
    .csr_wen_gate (csr_wen_gate),
    .halt         (halt),
    .hang         (hang),
    .state_o      (state_o),
    .inst_cnt     (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phase of the current instruction, captured decode, retire count.
  int          m_state = 0;
  int          m_k = 0;
  logic [6:0]  m_op = '0;
  bit          m_eb = 1'b0;
  bit          m_hang = 1'b0;
  int unsigned m_cnt = 0;

  always @(negedge clk) begin : cmp
    int nxt;
    bit exp_wd;
    bit e_commit;
    if (run) begin
      if (!rst_n) begin
        m_state = 0; m_k = 0; m_cnt = 0; m_hang = 1'b0; m_eb = 1'b0;
      end
      exp_wd = 1'b0;
`ifdef NPC_SEQ_WDT_EN
      exp_wd = (m_state == 1 || m_state == 3) && (m_k == WDT);
`endif
      e_commit = (m_state == 4) && wbu_valid;
      chk("ifu_req",      ifu_req,      (m_state == 1) && !exp_wd);
      chk("lsu_req",      lsu_req,      (m_state == 3) && !exp_wd);
      chk("commit",       commit,       e_commit);
      chk("pc_wen",       pc_wen,       e_commit);
      chk("gpr_wen_gate", gpr_wen_gate, e_commit);
      chk("csr_wen_gate", csr_wen_gate, e_commit);
      chk("halt",         halt,         m_state == 5);
      chk("hang",         hang,         m_hang);
      chk("state_o",      state_o,      m_state);
      chk("inst_cnt",     inst_cnt,     m_cnt);
      if (rst_n) begin
        nxt = m_state;
        case (m_state)
          0: nxt = 1;
          1: if (exp_wd) nxt = 5;
             else if (ifu_valid) begin m_op = opcode; m_eb = is_ebreak; nxt = 2; end
          2: nxt = (m_op == LD || m_op == ST) ? 3 : 4;
          3: if (exp_wd) nxt = 5; else if (lsu_valid) nxt = 4;
          4: if (wbu_valid) begin m_cnt = (m_cnt + 1) % (1 << CW); nxt = m_eb ? 5 : 1; end
          default: nxt = 5;
        endcase
        if (exp_wd) m_hang = 1'b1;
        m_k = (nxt == m_state) ? m_k + 1 : 0;
        m_state = nxt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_inst(input logic [6:0] op, input logic eb);
    ifu_valid = 1'b1; opcode = op; is_ebreak = eb;
    step();
    ifu_valid = 1'b0; opcode = 7'($urandom); is_ebreak = 1'($urandom);
    step();
    if (op == LD || op == ST) begin
      lsu_valid = 1'b1;
      step();
      lsu_valid = 1'b0;
    end
    wbu_valid = 1'b1;
    step();
    wbu_valid = 1'b0;
  endtask

  function automatic logic [6:0] pick_op();
    case ($urandom % 9)
      0: return LD;
      1: return ST;
      2: return ADDI;
      3: return 7'b0110011;
      4: return 7'b1101111;
      5: return 7'b1100111;
      6: return SYS;
      7: return 7'b0110111;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not complete, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int n, g;
    run = 1'b1;
    step(); step();
    chk("reset_state", state_o, 0);
    chk("reset_cnt", inst_cnt, 0);
    chk("reset_ifu_req", ifu_req, 0);

    // addi with one-cycle fetch latency
    rst_n = 1'b1;
    step();
    chk("t1_fetch", state_o, 1);
    chk("t1_ifu_req", ifu_req, 1);
    ifu_valid = 1'b1; opcode = ADDI;
    step();
    ifu_valid = 1'b0;
    chk("t1_exec", state_o, 2);
    step();
    chk("t1_wb", state_o, 4);
    #1 chk("t1_no_commit_wait", commit, 0);
    wbu_valid = 1'b1;
    #1 chk("t1_commit", commit, 1);
    chk("t1_gpr_gate", gpr_wen_gate, 1);
    step();
    wbu_valid = 1'b0;
    chk("t1_back_fetch", state_o, 1);
    chk("t1_cnt", inst_cnt, 1);

    // load with 5-cycle memory wait
    ifu_valid = 1'b1; opcode = LD;
    step();
    ifu_valid = 1'b0;
    step();
    chk("t2_mem", state_o, 3);
    n = 0; g = 0;
    for (int i = 0; i < 5; i++) begin
      if (lsu_req) n++;
      if (gpr_wen_gate || csr_wen_gate || commit) g++;
      step();
    end
    chk("t2_lsu_req_cycles", n, 5);
    chk("t2_gates_quiet", g, 0);
    lsu_valid = 1'b1; wbu_valid = 1'b1;
    #1 chk("t2_no_commit_in_mem", commit, 0);
    step();
    lsu_valid = 1'b0;
    chk("t2_wb", state_o, 4);
    #1 chk("t2_commit", commit, 1);
    step();
    wbu_valid = 1'b0;
    chk("t2_cnt", inst_cnt, 2);

    // ebreak as the 4th instruction
    do_inst(ADDI, 1'b0);
    do_inst(SYS, 1'b1);
    chk("t3_halt", halt, 1);
    chk("t3_state", state_o, 5);
    chk("t3_cnt", inst_cnt, 4);
    n = 0;
    ifu_valid = 1'b1; lsu_valid = 1'b1; wbu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 if (ifu_req || lsu_req || commit) n++;
      step();
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0; wbu_valid = 1'b0;
    chk("t3_quiet_after_halt", n, 0);
    chk("t3_cnt_hold", inst_cnt, 4);

    // reset mid-memory wait, then a stale lsu_valid
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ifu_valid = 1'b1; opcode = ST;
    step();
    ifu_valid = 1'b0;
    step();
    chk("t4_lsu_req", lsu_req, 1);
    wbu_valid = 1'b1;
    rst_n = 1'b0;
    #1 chk("t4_lsu_req_drop", lsu_req, 0);
    chk("t4_state", state_o, 0);
    chk("t4_commit", commit, 0);
    step();
    wbu_valid = 1'b0; lsu_valid = 1'b1; rst_n = 1'b1;
    step();
    chk("t4_refetch", state_o, 1);
    step();
    chk("t4_stale_ignored", state_o, 1);
    chk("t4_stale_no_lsu_req", lsu_req, 0);
    lsu_valid = 1'b0;
    do_inst(ADDI, 1'b0);
    chk("t4_cnt", inst_cnt, 1);

    // fetch that never returns
`ifdef NPC_SEQ_WDT_EN
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (ifu_req) n++;
      step();
    end
    chk("t5_req_cycles", n, WDT);
    chk("t5_hang", hang, 1);
    chk("t5_halt", halt, 1);
    chk("t5_ifu_req", ifu_req, 0);
`else
    repeat (100) step();
    chk("t5_still_fetch", state_o, 1);
    chk("t5_hang", hang, 0);
    chk("t5_ifu_req", ifu_req, 1);
`endif

    // counter wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < (1 << CW) - 1; i++) do_inst(pick_op() == LD ? LD : ADDI, 1'b0);
    chk("t6_cnt_max", inst_cnt, (1 << CW) - 1);
    do_inst(ADDI, 1'b0);
    chk("t6_cnt_wrap", inst_cnt, 0);
    chk("t6_no_halt", halt, 0);
    chk("t6_state", state_o, 1);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      ifu_valid = ($urandom % 3) == 0;
      lsu_valid = ($urandom % 3) == 0;
      wbu_valid = ($urandom % 2) == 0;
      opcode    = pick_op();
      is_ebreak = ($urandom % 25) == 0;
      if (!rst_n)                                   rst_n = 1'($urandom);
      else if (m_state == 5 && ($urandom % 8) == 0) rst_n = 1'b0;
      else if (($urandom % 400) == 0)               rst_n = 1'b0;
      step();
    end

    rst_n = 1'b1;
    step();
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
